// File: rtl/oclib_pkg.sv
// Shared encodings for the license manager: license modes, FSM states,
// plaintext layout and the XXTEA mixing function.
package oclib_pkg;

  localparam logic [31:0] XXTEA_DELTA  = 32'h9e3779b9;
  // Initial decrypt sum for a two-word block: 32 rounds * DELTA.
  localparam logic [31:0] XXTEA_SUM0   = 32'hc6ef3720;
  localparam logic [31:0] MAGIC_SERIAL = 32'h12345678;

  typedef enum logic [1:0] {
    MODE_PERM    = 2'b00,
    MODE_TIMED   = 2'b01,
    MODE_REVOKE  = 2'b10,
    MODE_INVALID = 2'b11
  } lic_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECRYPT,
    ST_CHECK,
    ST_LOCKOUT
  } lic_state_e;

  typedef struct packed {
    logic [23:0] id;
    lic_mode_e   mode;
    logic [1:0]  rsvd;
    logic [3:0]  feature;
    logic [31:0] serial;
  } license_t;

  function automatic logic [31:0] xxtea_mx(input logic [31:0] z, input logic [31:0] y,
                                           input logic [31:0] sum, input logic [31:0] k);
    return (((z >> 5) ^ (y << 2)) + ((y >> 3) ^ (z << 4))) ^ ((sum ^ y) + (k ^ z));
  endfunction

endpackage

// File: rtl/oclib_xxtea.sv
// Iterative XXTEA decryptor for one 64-bit block (v0 = block[31:0]),
// one full round per clock, 32 rounds.
module oclib_xxtea
  import oclib_pkg::*;
#(
  parameter logic [127:0] Key = 128'h44444444_33333333_22222222_11111111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [63:0] block_i,
  output logic        done_o,
  output logic [63:0] block_o
);

  logic        run_q, done_q;
  logic [4:0]  round_q;
  logic [31:0] sum_q, v0_q, v1_q, v0_d, v1_d;

  function automatic logic [31:0] kw(input logic [1:0] idx);
    return Key[{idx, 5'd0} +: 32];
  endfunction

  always_comb begin
    v1_d = v1_q - xxtea_mx(v0_q, v0_q, sum_q, kw(2'b01 ^ sum_q[3:2]));
    v0_d = v0_q - xxtea_mx(v1_d, v1_d, sum_q, kw(sum_q[3:2]));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      round_q <= '0;
      sum_q   <= '0;
      v0_q    <= '0;
      v1_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        v0_q    <= block_i[31:0];
        v1_q    <= block_i[63:32];
        sum_q   <= XXTEA_SUM0;
        round_q <= 5'd31;
        run_q   <= 1'b1;
      end else if (run_q) begin
        v0_q  <= v0_d;
        v1_q  <= v1_d;
        sum_q <= sum_q - XXTEA_DELTA;
        if (round_q == 5'd0) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          round_q <= round_q - 5'd1;
        end
      end
    end
  end

  assign done_o  = done_q;
  assign block_o = {v1_q, v0_q};

endmodule

// File: rtl/oc_license_manager.sv
// License manager: decrypts a license blob, validates it against this device
// and bitstream, and grants permanent or timed feature unlocks with lockout.
module oc_license_manager
  import oclib_pkg::*;
#(
  parameter int unsigned    ClockHz            = 100_000_000,
  parameter logic [31:0]    BitstreamID        = 32'h89abcdef,
  parameter logic [127:0]   BitstreamKey       = 128'h44444444_33333333_22222222_11111111,
  parameter int             NumFeatures        = 4,
  parameter bit             EnableSkeletonKey  = 1'b0,
  parameter bit             EnableTimedLicense = 1'b0,
  parameter int unsigned    TimedSeconds       = 3600,
  parameter int             MaxFailures        = 4,
  parameter int unsigned    LockoutCycles      = 1_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            serial,
  input  logic                   go,
  input  logic [63:0]            ciphertext,
  output logic                   busy,
  output logic                   done,
  output logic                   accepted,
  output logic                   rejected,
  output logic [NumFeatures-1:0] featureUnlocked,
  output logic                   lockedOut,
  output logic [7:0]             failCount
);

  localparam longint unsigned TimedTicks = 64'(TimedSeconds) * 64'(ClockHz);
  localparam int TW = (TimedTicks > 1) ? $clog2(TimedTicks) : 1;
  localparam int LW = (LockoutCycles > 1) ? $clog2(LockoutCycles + 1) : 1;

  lic_state_e state_q, state_d;
  logic [63:0] ct_q, xt_block;
  logic        start_q, xt_done;
  license_t    pt_q;
  logic [NumFeatures-1:0]         perm_q, fu_q;
  logic [NumFeatures-1:0][TW-1:0] timer_q;
  logic [7:0]    fail_q, fail_inc;
  logic [LW-1:0] lock_q;
  logic done_q, acc_q, rej_q, lic_ok, to_lockout;

  oclib_xxtea #(.Key(BitstreamKey)) u_xxtea (
    .clock   (clock),
    .reset   (reset),
    .start_i (start_q),
    .block_i (ct_q),
    .done_o  (xt_done),
    .block_o (xt_block)
  );

  always_comb begin
    lic_ok = (pt_q.id == BitstreamID[31:8]) && (pt_q.rsvd == 2'b00) &&
             ({28'd0, pt_q.feature} < 32'(NumFeatures)) && (pt_q.mode != MODE_INVALID) &&
             ((pt_q.mode != MODE_TIMED) || EnableTimedLicense) &&
             ((pt_q.serial == serial) || (EnableSkeletonKey && pt_q.serial == MAGIC_SERIAL));
    fail_inc   = (fail_q >= 8'(MaxFailures)) ? fail_q : fail_q + 8'd1;
    to_lockout = !lic_ok && (fail_inc >= 8'(MaxFailures));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go) state_d = ST_DECRYPT;
      ST_DECRYPT: if (xt_done) state_d = ST_CHECK;
      ST_CHECK:   state_d = to_lockout ? ST_LOCKOUT : ST_IDLE;
      ST_LOCKOUT: if (lock_q == '0) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    lockedOut = (state_q == ST_LOCKOUT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ct_q    <= '0;
      start_q <= 1'b0;
      pt_q    <= '0;
      perm_q  <= '0;
      timer_q <= '0;
      fu_q    <= '0;
      fail_q  <= '0;
      lock_q  <= '0;
      done_q  <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      acc_q   <= 1'b0;
      rej_q   <= 1'b0;
      if (state_q == ST_IDLE && go) begin
        ct_q    <= ciphertext;
        start_q <= 1'b1;
      end
      if (state_q == ST_DECRYPT && xt_done) pt_q <= license_t'(xt_block);
      if (state_q == ST_CHECK) begin
        done_q <= 1'b1;
        acc_q  <= lic_ok;
        rej_q  <= !lic_ok;
        fail_q <= lic_ok ? 8'd0 : fail_inc;
        if (to_lockout) lock_q <= LW'(LockoutCycles - 1);
      end
      if (state_q == ST_LOCKOUT) begin
        if (lock_q == '0) fail_q <= 8'd0;
        else              lock_q <= lock_q - 1'b1;
      end
      // A license hit on a feature overrides that cycle's timer decrement.
      for (int i = 0; i < NumFeatures; i++) begin
        if (timer_q[i] != '0) timer_q[i] <= timer_q[i] - 1'b1;
        if (state_q == ST_CHECK && lic_ok && pt_q.feature == 4'(i)) begin
          case (pt_q.mode)
            MODE_PERM:   perm_q[i] <= 1'b1;
            MODE_TIMED:  timer_q[i] <= TW'(TimedTicks - 1);
            MODE_REVOKE: begin
              perm_q[i]  <= 1'b0;
              timer_q[i] <= '0;
            end
            default: ;
          endcase
        end
        fu_q[i] <= perm_q[i] | (timer_q[i] != '0);
      end
    end
  end

  assign done            = done_q;
  assign accepted        = acc_q;
  assign rejected        = rej_q;
  assign featureUnlocked = fu_q;
  assign failCount       = fail_q;

endmodule
